fifo_sync_controller: RTL
=========================

FIFO_SYNC_CONTROLLER -- requirements
Module: fifo_sync_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, word slots; power of two, >=4.
REQ-003 SHALL have parameter ALMOST_FULL_LEVEL, default DEPTH-2, level at which almost_full asserts (1..DEPTH).
REQ-004 SHALL use local ADDR_WIDTH = $clog2(DATA_WIDTH*(DEPTH-1)) and LEVEL_WIDTH = $clog2(DEPTH+1).
REQ-005 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port flush  in  1  synchronous clear of contents.
REQ-008 SHALL have ports in_valid in 1, in_ready out 1, in_data in DATA_WIDTH: push handshake.
REQ-009 SHALL have ports out_valid out 1, out_ready in 1, out_data out DATA_WIDTH: pop handshake.
REQ-010 SHALL have ports mem_write_enable out 1, mem_write_address out ADDR_WIDTH, mem_write_data out DATA_WIDTH: memory write side.
REQ-011 SHALL have ports mem_read_address out ADDR_WIDTH, mem_read_data in DATA_WIDTH: memory read side (memory read is combinational).
REQ-012 SHALL have ports level out LEVEL_WIDTH, full out 1, empty out 1, almost_full out 1, overflow out 1: status.

Function
REQ-013 SHALL hold write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, plus level counter 0..DEPTH.
REQ-014 SHALL drive mem_write_address = wr_ptr*DATA_WIDTH and mem_read_address = rd_ptr*DATA_WIDTH (bit offsets; always fit ADDR_WIDTH).
REQ-015 SHALL assert in_ready = !full && !flush; push occurs when in_valid && in_ready.
REQ-016 SHALL assert out_valid = !empty && !flush; pop occurs when out_valid && out_ready.
REQ-017 SHALL drive mem_write_enable = push, mem_write_data = in_data, combinationally in the push cycle.
REQ-018 SHALL drive out_data = mem_read_data combinationally (show-ahead; head word valid whenever out_valid).
REQ-019 SHALL advance wr_ptr by 1 on push and rd_ptr by 1 on pop, wrapping DEPTH-1 -> 0.
REQ-020 SHALL update level: +1 push only, -1 pop only, unchanged on both or neither.
REQ-021 SHALL drive empty = (level == 0), full = (level == DEPTH), almost_full = (level >= ALMOST_FULL_LEVEL), all from registered level.
REQ-022 SHALL give push-to-out_valid latency of one cycle; no same-cycle pass-through when empty.
REQ-023 SHALL refuse push when full even if a pop occurs in the same cycle (in_ready depends on registered state only).
REQ-024 SHALL accept simultaneous push and pop whenever 0 < level < DEPTH, with level unchanged.
REQ-025 SHALL set overflow (sticky) on any cycle with in_valid && full && !flush; only reset or flush clear it.
REQ-026 SHALL, on flush, set wr_ptr, rd_ptr, level to 0 and clear overflow at the next edge; flush overrides any push/pop in that cycle (none occur).
REQ-027 SHALL never modify memory contents except through mem_write_enable; flush leaves stale data in memory.

Reset
REQ-028 SHALL, while reset is high at a rising edge, set wr_ptr=0, rd_ptr=0, level=0, overflow=0; reset has priority over flush, push and pop.
REQ-029 SHALL present after reset: in_ready=1, out_valid=0, empty=1, full=0, almost_full=0 (ALMOST_FULL_LEVEL>0), overflow=0, level=0, mem_write_enable=0 while in_valid=0.
REQ-030 SHALL discard any partially completed handshake when reset asserts mid-operation; the FIFO is empty the cycle after.

Verification
REQ-031 SHALL cover fill/drain: DEPTH=8, DW=8, push 0x01..0x08 -> full=1, in_ready=0, level=8, almost_full from level 6; pop all -> data 0x01..0x08 in order, empty=1.
REQ-032 SHALL cover wrap-around: push 5, pop 5, push 8 (0xA0..0xA7) -> mem_write_address sequence 40,48,56,0,8,..., read order 0xA0..0xA7.
REQ-033 SHALL cover simultaneous push/pop at level 3 for 10 cycles -> level stays 3, data order preserved; at full with out_ready=1 and in_valid=1 -> pop only, level 7 next cycle.
REQ-034 SHALL cover overflow: full, in_valid=1 one cycle -> overflow=1 and stays 1 after draining; flush -> overflow=0, level=0, empty=1.
REQ-035 SHALL cover flush with in_valid=1, out_ready=1 at level 4 -> in_ready=0, out_valid=0, mem_write_enable=0 that cycle; level=0 next cycle.
REQ-036 SHALL cover reset mid-stream at level 5 with push pending -> next cycle level=0, empty=1, in_ready=1, pointers 0 (addresses 0).

Source files
------------

// File: rtl/fifo_sync_controller.sv
// Synchronous FIFO controller driving an external memory with a combinational read port.
// Tracks write/read pointers and fill level, and raises a sticky overflow flag on refused pushes.
module fifo_sync_controller #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned DEPTH             = 8,
    parameter int unsigned ALMOST_FULL_LEVEL = DEPTH - 2,
    localparam int unsigned ADDR_WIDTH       = $clog2(DATA_WIDTH * (DEPTH - 1)),
    localparam int unsigned LEVEL_WIDTH      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   mem_write_enable,
    output logic [ADDR_WIDTH-1:0]  mem_write_address,
    output logic [DATA_WIDTH-1:0]  mem_write_data,
    output logic [ADDR_WIDTH-1:0]  mem_read_address,
    input  logic [DATA_WIDTH-1:0]  mem_read_data,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   overflow
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 push;
    logic                 pop;

    // Status flags derive only from the registered level, so in_ready never sees this cycle's pop.
    assign empty       = (level == LEVEL_WIDTH'(0));
    assign full        = (level == LEVEL_WIDTH'(DEPTH));
    assign almost_full = (level >= LEVEL_WIDTH'(ALMOST_FULL_LEVEL));

    assign in_ready  = !full && !flush;
    assign out_valid = !empty && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Memory addresses are bit offsets of the word slot.
    assign mem_write_enable  = push;
    assign mem_write_data    = in_data;
    assign mem_write_address = ADDR_WIDTH'(32'(wr_ptr) * DATA_WIDTH);
    assign mem_read_address  = ADDR_WIDTH'(32'(rd_ptr) * DATA_WIDTH);
    assign out_data          = mem_read_data;

    // Pointer, level and overflow state; reset outranks flush, flush outranks push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            unique case ({push, pop})
                2'b10:   level <= level + LEVEL_WIDTH'(1);
                2'b01:   level <= level - LEVEL_WIDTH'(1);
                default: level <= level;
            endcase
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
